// File: rtl/pool_stream_buffer_pkg.sv
// Shared types and defaults for the pooled-pixel stream buffer.
// Holds the FSM state encoding and a width helper used to size the ports.
package pool_stream_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int CHANNEL        = 8;
    localparam int DEF_MAP_WIDTH  = 28;
    localparam int DEF_MAP_HEIGHT = 28;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index width for n items, never below one bit.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_stream_buffer_sync_fifo_sa.sv
// Show-ahead synchronous FIFO: the head entry is visible on rd_data whenever
// the FIFO is not empty; push/pop arrive already qualified by the caller.
module sync_fifo_sa
    import pool_stream_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [bits_for(DEPTH):0] count
);

    localparam int AW = bits_for(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // Output is forced to zero when empty so a reset clears the data ports too.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pool_stream_buffer.sv
// Elastic buffer between block-1 maxpool and block-2 conv: captures un-stallable
// 8-channel beats, tags them with pooled-map coordinates and replays them with valid/ready.
module pool_stream_buffer
    import pool_stream_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAP_WIDTH  = DEF_MAP_WIDTH,
    parameter int MAP_HEIGHT = DEF_MAP_HEIGHT,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in_0,
    input  logic [DATA_WIDTH-1:0]           data_in_1,
    input  logic [DATA_WIDTH-1:0]           data_in_2,
    input  logic [DATA_WIDTH-1:0]           data_in_3,
    input  logic [DATA_WIDTH-1:0]           data_in_4,
    input  logic [DATA_WIDTH-1:0]           data_in_5,
    input  logic [DATA_WIDTH-1:0]           data_in_6,
    input  logic [DATA_WIDTH-1:0]           data_in_7,
    input  logic                            ready_in,
    output logic                            valid_out,
    output logic [DATA_WIDTH-1:0]           data_out_0,
    output logic [DATA_WIDTH-1:0]           data_out_1,
    output logic [DATA_WIDTH-1:0]           data_out_2,
    output logic [DATA_WIDTH-1:0]           data_out_3,
    output logic [DATA_WIDTH-1:0]           data_out_4,
    output logic [DATA_WIDTH-1:0]           data_out_5,
    output logic [DATA_WIDTH-1:0]           data_out_6,
    output logic [DATA_WIDTH-1:0]           data_out_7,
    output logic [bits_for(MAP_WIDTH)-1:0]  col_out,
    output logic [bits_for(MAP_HEIGHT)-1:0] row_out,
    output logic                            last_out,
    output logic [bits_for(DEPTH):0]        fill_level,
    output logic                            overflow,
    output logic                            done
);

    localparam int CW        = bits_for(MAP_WIDTH);
    localparam int RW        = bits_for(MAP_HEIGHT);
    localparam int DATA_BITS = CHANNEL * DATA_WIDTH;
    localparam int ENTRY_W   = RW + CW + DATA_BITS;

    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 at_last_in;
    logic                 in_last;
    logic                 out_last;
    logic                 pending_q;
    state_t               state_q;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   head;
    logic [DATA_BITS-1:0] head_data;

    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_in;
    assign push      = valid_in && (!fifo_full || pop);

    assign wr_entry = {row_q, col_q, data_in_7, data_in_6, data_in_5, data_in_4,
                       data_in_3, data_in_2, data_in_1, data_in_0};

    sync_fifo_sa #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fill_level)
    );

    assign {row_out, col_out, head_data} = head;
    assign data_out_0 = head_data[0*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_1 = head_data[1*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_2 = head_data[2*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_3 = head_data[3*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_4 = head_data[4*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_5 = head_data[5*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_6 = head_data[6*DATA_WIDTH +: DATA_WIDTH];
    assign data_out_7 = head_data[7*DATA_WIDTH +: DATA_WIDTH];

    assign last_out   = valid_out && (row_out == RW'(MAP_HEIGHT-1)) && (col_out == CW'(MAP_WIDTH-1));
    assign at_last_in = (row_q == RW'(MAP_HEIGHT-1)) && (col_q == CW'(MAP_WIDTH-1));
    assign in_last    = valid_in && at_last_in;
    assign out_last   = pop && last_out;

    // Advances on every input beat, dropped or not, so the frame stays aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (valid_in) begin
            if (col_q == CW'(MAP_WIDTH-1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(MAP_HEIGHT-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (valid_in && !push) begin
            overflow <= 1'b1;
        end
    end

    // A second frame end seen before the first is drained parks in pending_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_last)   state_q <= ST_DRAIN;
                    else if (push) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (in_last) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_last) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                    if (in_last) pending_q <= 1'b1;
                end
                ST_DONE: begin
                    if (pending_q || in_last) begin
                        state_q   <= ST_DRAIN;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_stream_buffer.sv
// Directed bench for pool_stream_buffer on a 4x4 map with a 4-entry FIFO.
// Expected values come from hand-computed indices and a small queue model.
module tb_pool_stream_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] din  [8];
    logic [31:0] dout [8];
    logic        valid_out;
    logic [1:0]  col_out;
    logic [1:0]  row_out;
    logic        last_out;
    logic [2:0]  fill_level;
    logic        overflow;
    logic        done;

    int errors = 0;
    int checks = 0;
    int q[$];
    int sent;
    int dones;
    int cyc;
    logic [15:0] pat;

    always #5 clk = ~clk;

    pool_stream_buffer #(
        .DATA_WIDTH (32),
        .MAP_WIDTH  (4),
        .MAP_HEIGHT (4),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in_0  (din[0]),
        .data_in_1  (din[1]),
        .data_in_2  (din[2]),
        .data_in_3  (din[3]),
        .data_in_4  (din[4]),
        .data_in_5  (din[5]),
        .data_in_6  (din[6]),
        .data_in_7  (din[7]),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out_0 (dout[0]),
        .data_out_1 (dout[1]),
        .data_out_2 (dout[2]),
        .data_out_3 (dout[3]),
        .data_out_4 (dout[4]),
        .data_out_5 (dout[5]),
        .data_out_6 (dout[6]),
        .data_out_7 (dout[7]),
        .col_out    (col_out),
        .row_out    (row_out),
        .last_out   (last_out),
        .fill_level (fill_level),
        .overflow   (overflow),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pix(input int base, input int k, input int i);
        return 32'(base + k*16 + i);
    endfunction

    task automatic set_beat(input logic v, input int base, input int i);
        valid_in = v;
        for (int k = 0; k < 8; k++) din[k] = pix(base, k, i);
    endtask

    task automatic check_head(input string tag, input int base, input int i,
                              input int row, input int col, input logic last);
        check({tag, ".d0"},   dout[0],  pix(base, 0, i));
        check({tag, ".d7"},   dout[7],  pix(base, 7, i));
        check({tag, ".row"},  row_out,  row);
        check({tag, ".col"},  col_out,  col);
        check({tag, ".last"}, last_out, last);
    endtask

    initial begin
        reset    = 1'b1;
        ready_in = 1'b0;
        set_beat(1'b0, 0, 0);
        repeat (2) tick();
        check("rst.valid", valid_out, 0);
        check("rst.fill",  fill_level, 0);
        check("rst.ovf",   overflow, 0);
        check("rst.done",  done, 0);
        check("rst.last",  last_out, 0);
        check("rst.d0",    dout[0], 0);
        reset = 1'b0;
        tick();

        // Frame streamed straight through with the consumer always ready.
        ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_beat(1'b1, 0, i);
            tick();
            check("t1.valid", valid_out, 1);
            check("t1.fill",  fill_level, 1);
            check("t1.done",  done, 0);
            check_head("t1", 0, i, i / 4, i % 4, i == 15);
        end
        set_beat(1'b0, 0, 0);
        tick();
        check("t1.done_pulse", done, 1);
        check("t1.empty",      valid_out, 0);
        check("t1.fill0",      fill_level, 0);
        check("t1.ovf",        overflow, 0);
        tick();
        check("t1.done_low",   done, 0);

        // Full FIFO with simultaneous push and pop keeps the level at DEPTH.
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, 32'h200, i);
            tick();
            check("t3.fill", fill_level, i + 1);
        end
        check_head("t3.h0", 32'h200, 0, 0, 0, 1'b0);
        ready_in = 1'b1;
        set_beat(1'b1, 32'h200, 4);
        tick();
        check("t3.fill_same", fill_level, 4);
        check("t3.ovf",       overflow, 0);
        set_beat(1'b0, 0, 0);
        for (int j = 1; j <= 4; j++) begin
            check_head("t3.drain", 32'h200, j, j / 4, j % 4, 1'b0);
            tick();
        end
        check("t3.empty", valid_out, 0);

        // Overflow: six beats into four entries with the consumer stalled.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_beat(1'b1, 32'h300, i);
            tick();
            check("t2.fill", fill_level, (i < 4) ? i + 1 : 4);
            check("t2.ovf",  overflow, i >= 4);
        end
        set_beat(1'b0, 0, 0);
        tick();
        check("t2.hold_fill", fill_level, 4);
        check_head("t2.hold", 32'h300, 0, 0, 0, 1'b0);
        ready_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_head("t2.out", 32'h300, j, 0, j, 1'b0);
            tick();
        end
        check("t2.empty",   valid_out, 0);
        check("t2.fill0",   fill_level, 0);
        check("t2.ovf_sticky", overflow, 1);

        // Two frames with an irregular ready pattern, checked against a queue model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pat   = 16'b1011_0010_1101_0110;
        sent  = 0;
        dones = 0;
        cyc   = 0;
        while ((sent < 32 || q.size() != 0) && cyc < 400) begin
            ready_in = pat[0];
            pat = {pat[0], pat[15:1]};
            check("t4.valid", valid_out, q.size() != 0);
            if (q.size() != 0) begin
                check_head("t4", 32'h400, q[0], (q[0] / 4) % 4, q[0] % 4, (q[0] % 16) == 15);
                if (ready_in) void'(q.pop_front());
            end
            if (sent < 32 && q.size() < 3) begin
                set_beat(1'b1, 32'h400, sent);
                q.push_back(sent);
                sent++;
            end else begin
                set_beat(1'b0, 0, 0);
            end
            tick();
            cyc++;
            if (done) dones++;
        end
        check("t4.timeout", cyc < 400, 1);
        set_beat(1'b0, 0, 0);
        repeat (3) begin
            tick();
            if (done) dones++;
        end
        check("t4.dones", dones, 2);
        check("t4.ovf",   overflow, 0);

        // Asynchronous reset in the middle of a frame.
        ready_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_beat(1'b1, 32'h500, i);
            tick();
        end
        check("t5.ovf_before",  overflow, 1);
        check("t5.fill_before", fill_level, 4);
        set_beat(1'b1, 32'h500, 7);
        #2;
        reset = 1'b1;
        #1;
        check("t5.valid", valid_out, 0);
        check("t5.fill",  fill_level, 0);
        check("t5.ovf",   overflow, 0);
        check("t5.done",  done, 0);
        check("t5.last",  last_out, 0);
        check("t5.col",   col_out, 0);
        check("t5.row",   row_out, 0);
        check("t5.d0",    dout[0], 0);
        check("t5.d7",    dout[7], 0);
        tick();
        reset    = 1'b0;
        ready_in = 1'b1;
        set_beat(1'b1, 32'h600, 0);
        tick();
        check_head("t5.new0", 32'h600, 0, 0, 0, 1'b0);
        check("t5.new_fill", fill_level, 1);
        check("t5.new_ovf",  overflow, 0);
        set_beat(1'b1, 32'h600, 1);
        tick();
        check_head("t5.new1", 32'h600, 1, 0, 1, 1'b0);
        set_beat(1'b0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
